ise_sort_param: RTL and testbench

// - Parametrised image sorting engine. Successor to the fixed 32-image, 128x128 ISE.
// - Streams RGB pixels, classifies each image by its dominant colour, and computes that colour's mean intensity.
// - Insertion-sorts the images and, after every image has arrived, emits the sorted list as one index per cycle.

---
 rtl/ise_sort_param.sv | 242 ++++++++++++++++++++++++
 tb/tb_ise_sort_param.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ise_sort_param.sv
// ise_sort_param: streams RGB images and classifies each one by its dominant colour
// and mean intensity, insertion-sorts them, then emits the sorted index list.
// ISE_DESCEND_EN: when defined, intensity sorts descending within each colour.
module ise_sort_param #(
    parameter int IMG_NUM = 32,
    parameter int IMG_PIX = 16384,
    parameter int CH_W    = 8,
    parameter int IDX_W   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [IDX_W-1:0]  image_in_index,
    input  logic [3*CH_W-1:0] pixel_in,
    output logic              busy,
    output logic              out_valid,
    output logic [1:0]        color_index,
    output logic [IDX_W-1:0]  image_out_index
);

    localparam int SUM_W = CH_W + $clog2(IMG_PIX);
    localparam int PIX_W = $clog2(IMG_PIX + 1);
    localparam int NUM_W = $clog2(IMG_NUM + 1);
    localparam int DC_W  = $clog2(SUM_W + 1);
    localparam int KEY_W = CH_W + 2;

    typedef enum logic [2:0] {ACC, CLS, DIV, INS, OUT} state_t;

    state_t             state_q, state_d;
    logic [PIX_W-1:0]   pix_cnt;
    logic [IDX_W-1:0]   cur_id;
    logic [PIX_W-1:0]   cnt [3];
    logic [SUM_W-1:0]   sum [3];
    logic [CH_W-1:0]    ch  [3];
    logic [1:0]         dom;
    logic               accept, last_pix;

    logic [1:0]         sel_c, col_q;
    logic [SUM_W-1:0]   sel_cnt, sel_sum;
    logic [SUM_W-1:0]   dvs, quo, rem;
    logic [SUM_W:0]     rem_sh, rem_df;
    logic [DC_W-1:0]    div_cnt;
    logic               div_last;

    logic [KEY_W-1:0]   buf_key [IMG_NUM];
    logic [KEY_W-1:0]   up_key  [IMG_NUM];
    logic [KEY_W-1:0]   dn_key  [IMG_NUM];
    logic [IDX_W-1:0]   buf_id  [IMG_NUM];
    logic [IDX_W-1:0]   up_id   [IMG_NUM];
    logic [IDX_W-1:0]   dn_id   [IMG_NUM];
    logic [IMG_NUM-1:0] gt, gt_prev;
    logic [CH_W-1:0]    ikey;
    logic [KEY_W-1:0]   new_key;
    logic [NUM_W-1:0]   n_img, out_cnt;
    logic               img_last, out_last;

    assign ch[0] = pixel_in[3*CH_W-1:2*CH_W];
    assign ch[1] = pixel_in[2*CH_W-1:CH_W];
    assign ch[2] = pixel_in[CH_W-1:0];

    assign accept   = in_valid && (state_q == ACC);
    assign last_pix = accept && (pix_cnt == PIX_W'(IMG_PIX - 1));
    assign div_last = (div_cnt == DC_W'(SUM_W - 1));
    assign img_last = (n_img == NUM_W'(IMG_NUM - 1));
    assign out_last = (out_cnt == NUM_W'(IMG_NUM - 1));

    assign color_index     = out_valid ? buf_key[0][KEY_W-1:CH_W] : 2'd0;
    assign image_out_index = out_valid ? buf_id[0] : '0;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ACC;
        else       state_q <= state_d;
    end

    // Next state, busy and out_valid.
    always_comb begin
        state_d   = state_q;
        busy      = 1'b1;
        out_valid = 1'b0;
        unique case (state_q)
            ACC: begin
                busy = 1'b0;
                if (last_pix) state_d = CLS;
            end
            CLS: state_d = DIV;
            DIV: if (div_last) state_d = INS;
            INS: state_d = img_last ? OUT : ACC;
            OUT: begin
                out_valid = 1'b1;
                if (out_last) state_d = ACC;
            end
            default: state_d = ACC;
        endcase
    end

    // Dominant channel of the incoming pixel, ties go R then G.
    always_comb begin
        if (ch[0] >= ch[1] && ch[0] >= ch[2]) dom = 2'd0;
        else if (ch[1] >= ch[2])              dom = 2'd1;
        else                                  dom = 2'd2;
    end

    // Per-image pixel counting and per-channel accumulation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_cnt <= '0;
            cur_id  <= '0;
            for (int c = 0; c < 3; c++) begin
                cnt[c] <= '0;
                sum[c] <= '0;
            end
        end else if (accept) begin
            pix_cnt <= last_pix ? '0 : pix_cnt + PIX_W'(1);
            if (pix_cnt == '0) cur_id <= image_in_index;
            for (int c = 0; c < 3; c++) begin
                if (dom == 2'(c)) begin
                    cnt[c] <= cnt[c] + PIX_W'(1);
                    sum[c] <= sum[c] + SUM_W'(ch[c]);
                end
            end
        end else if (state_q == INS) begin
            for (int c = 0; c < 3; c++) begin
                cnt[c] <= '0;
                sum[c] <= '0;
            end
        end
    end

    // Image colour: largest count, ties go R then G.
    always_comb begin
        if (cnt[0] >= cnt[1] && cnt[0] >= cnt[2]) begin
            sel_c   = 2'd0;
            sel_cnt = SUM_W'(cnt[0]);
            sel_sum = sum[0];
        end else if (cnt[1] >= cnt[2]) begin
            sel_c   = 2'd1;
            sel_cnt = SUM_W'(cnt[1]);
            sel_sum = sum[1];
        end else begin
            sel_c   = 2'd2;
            sel_cnt = SUM_W'(cnt[2]);
            sel_sum = sum[2];
        end
    end

    assign rem_sh = {rem, quo[SUM_W-1]};
    assign rem_df = rem_sh - {1'b0, dvs};

    // Restoring divider, one quotient bit per DIV cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_q   <= '0;
            dvs     <= '0;
            quo     <= '0;
            rem     <= '0;
            div_cnt <= '0;
        end else if (state_q == CLS) begin
            col_q   <= sel_c;
            dvs     <= sel_cnt;
            quo     <= sel_sum;
            rem     <= '0;
            div_cnt <= '0;
        end else if (state_q == DIV) begin
            if (!rem_df[SUM_W]) begin
                rem <= rem_df[SUM_W-1:0];
                quo <= {quo[SUM_W-2:0], 1'b1};
            end else begin
                rem <= rem_sh[SUM_W-1:0];
                quo <= {quo[SUM_W-2:0], 1'b0};
            end
            div_cnt <= div_cnt + DC_W'(1);
        end
    end

`ifdef ISE_DESCEND_EN
    assign ikey = ~quo[CH_W-1:0];
`else
    assign ikey = quo[CH_W-1:0];
`endif
    assign new_key = {col_q, ikey};

    // Insert position compare and shifted buffer views.
    always_comb begin
        gt = '0;
        for (int i = 0; i < IMG_NUM; i++) begin
            gt[i] = (NUM_W'(i) >= n_img) || (buf_key[i] > new_key);
            up_key[i] = '0;
            up_id[i]  = '0;
            dn_key[i] = '0;
            dn_id[i]  = '0;
        end
        gt_prev = gt << 1;
        for (int i = 1; i < IMG_NUM; i++) begin
            up_key[i] = buf_key[i-1];
            up_id[i]  = buf_id[i-1];
        end
        for (int i = 0; i < IMG_NUM - 1; i++) begin
            dn_key[i] = buf_key[i+1];
            dn_id[i]  = buf_id[i+1];
        end
    end

    // Sorted buffer: stable shift-insert, then drain from the head.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < IMG_NUM; i++) begin
                buf_key[i] <= '0;
                buf_id[i]  <= '0;
            end
            n_img   <= '0;
            out_cnt <= '0;
        end else begin
            unique case (state_q)
                INS: begin
                    for (int i = 0; i < IMG_NUM; i++) begin
                        if (gt[i]) begin
                            if (!gt_prev[i]) begin
                                buf_key[i] <= new_key;
                                buf_id[i]  <= cur_id;
                            end else begin
                                buf_key[i] <= up_key[i];
                                buf_id[i]  <= up_id[i];
                            end
                        end
                    end
                    n_img <= n_img + NUM_W'(1);
                end
                OUT: begin
                    for (int i = 0; i < IMG_NUM; i++) begin
                        buf_key[i] <= dn_key[i];
                        buf_id[i]  <= dn_id[i];
                    end
                    out_cnt <= out_last ? '0 : out_cnt + NUM_W'(1);
                    if (out_last) n_img <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ise_sort_param.sv
// tb_ise_sort_param: random and directed batches for ise_sort_param,
// checked against a stable-sort reference model of the classification rules.
module tb_ise_sort_param;

    localparam int N = 4;
    localparam int P = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [4:0] image_in_index;
    logic [23:0] pixel_in;
    logic       busy;
    logic       out_valid;
    logic [1:0] color_index;
    logic [4:0] image_out_index;

    ise_sort_param #(
        .IMG_NUM(N), .IMG_PIX(P), .CH_W(8), .IDX_W(5)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .image_in_index(image_in_index),
        .pixel_in(pixel_in),
        .busy(busy),
        .out_valid(out_valid),
        .color_index(color_index),
        .image_out_index(image_out_index)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic [23:0] px [N][P];
    logic [4:0]  ids [N];
    logic [6:0]  exp_o [N];
    logic [6:0]  t1c [N];

    int          brun, orun, idle_bad;
    int          busy_runs[$];
    int          out_runs[$];
    logic [6:0]  outs[$];

    // Observe outputs away from the rising edge.
    always @(negedge clk) begin
        if (busy) brun++;
        else if (brun > 0) begin
            busy_runs.push_back(brun);
            brun = 0;
        end
        if (out_valid) begin
            orun++;
            outs.push_back({color_index, image_out_index});
        end else begin
            if (orun > 0) begin
                out_runs.push_back(orun);
                orun = 0;
            end
            if (color_index != 2'd0 || image_out_index != 5'd0) idle_bad++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        brun = 0;
        orun = 0;
        idle_bad = 0;
        busy_runs.delete();
        out_runs.delete();
        outs.delete();
    endtask

    task automatic fill(input int j, input logic [23:0] p);
        for (int k = 0; k < P; k++) px[j][k] = p;
    endtask

    // Reference: classify each image, then stable-rank by key.
    task automatic model();
        int cnt[3], sum[3], v[3];
        int col[N], key[N];
        int c, r, mean;
        logic [23:0] q;
        for (int j = 0; j < N; j++) begin
            for (int k = 0; k < 3; k++) begin
                cnt[k] = 0;
                sum[k] = 0;
            end
            for (int p = 0; p < P; p++) begin
                q = px[j][p];
                v[0] = int'(q[23:16]);
                v[1] = int'(q[15:8]);
                v[2] = int'(q[7:0]);
                if (v[0] >= v[1] && v[0] >= v[2]) c = 0;
                else if (v[1] >= v[2]) c = 1;
                else c = 2;
                cnt[c] += 1;
                sum[c] += v[c];
            end
            c = 0;
            if (cnt[1] > cnt[c]) c = 1;
            if (cnt[2] > cnt[c]) c = 2;
            mean = sum[c] / cnt[c];
            col[j] = c;
`ifdef ISE_DESCEND_EN
            key[j] = c * 256 + (255 - mean);
`else
            key[j] = c * 256 + mean;
`endif
        end
        for (int j = 0; j < N; j++) begin
            r = 0;
            for (int k = 0; k < N; k++)
                if (key[k] < key[j] || (key[k] == key[j] && k < j)) r++;
            exp_o[r] = {2'(col[j]), ids[j]};
        end
    endtask

    task automatic send_px(input logic [23:0] p, input logic [4:0] id,
                           input bit gaps);
        int w;
        if (gaps) begin
            w = $urandom_range(0, 3);
            repeat (w) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
        end
        in_valid = 1'b1;
        pixel_in = p;
        image_in_index = id;
        w = 0;
        while (busy && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (busy) chk("accept_stuck", busy, 1'b0);
        @(negedge clk);
    endtask

    task automatic send_imgs(input int n, input bit gaps);
        for (int j = 0; j < n; j++)
            for (int p = 0; p < P; p++)
                send_px(px[j][p], (p == 0) ? ids[j] : 5'($urandom), gaps);
        in_valid = 1'b0;
    endtask

    task automatic run_batch(input bit gaps, input string nm);
        int w;
        #1;
        clear_mon();
        send_imgs(N, gaps);
        model();
        w = 0;
        while (outs.size() < N && w < 300) begin
            @(negedge clk);
            w++;
        end
        chk({nm, "_outcnt"}, outs.size(), N);
        repeat (3) @(negedge clk);
        chk({nm, "_orun"}, (out_runs.size() == 1) ? out_runs[0] : 0, N);
        chk({nm, "_nbrun"}, busy_runs.size(), N);
        for (int i = 0; i < N && i < busy_runs.size(); i++)
            chk({nm, "_brun"}, busy_runs[i], (i == N - 1) ? 18 : 14);
        for (int i = 0; i < N; i++)
            chk({nm, "_ord"}, (i < outs.size()) ? outs[i] : 7'h7f, exp_o[i]);
        chk({nm, "_idle"}, idle_bad, 0);
    endtask

    task automatic load_t1();
        fill(0, {8'd0, 8'd0, 8'd50});
        fill(1, {8'd90, 8'd0, 8'd0});
        fill(2, {8'd0, 8'd30, 8'd0});
        fill(3, {8'd40, 8'd0, 8'd0});
        for (int j = 0; j < N; j++) ids[j] = 5'(j);
    endtask

    task automatic chk_t1(input string nm);
        for (int i = 0; i < N; i++)
            chk(nm, (i < outs.size()) ? outs[i] : 7'h7f, t1c[i]);
    endtask

    initial begin
`ifdef ISE_DESCEND_EN
        t1c[0] = {2'd0, 5'd1};
        t1c[1] = {2'd0, 5'd3};
`else
        t1c[0] = {2'd0, 5'd3};
        t1c[1] = {2'd0, 5'd1};
`endif
        t1c[2] = {2'd1, 5'd2};
        t1c[3] = {2'd2, 5'd0};

        reset = 1'b1;
        in_valid = 1'b0;
        pixel_in = '0;
        image_in_index = '0;
        clear_mon();
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_oval", out_valid, 1'b0);
        chk("rst_col", color_index, 2'd0);
        chk("rst_idx", image_out_index, 5'd0);
        reset = 1'b0;
        @(negedge clk);

        load_t1();
        run_batch(1'b1, "t1");
        chk_t1("t1_const");

        for (int k = 0; k < P; k++)
            px[0][k] = (k < 8) ? {8'd9, 8'd1, 8'd1} : {8'd1, 8'd9, 8'd1};
        for (int k = 0; k < P; k++)
            px[1][k] = (k < 8) ? {8'd100, 8'd100, 8'd5} : {8'd0, 8'd0, 8'd50};
        fill(2, {8'd10, 8'd0, 8'd0});
        fill(3, {8'd8, 8'd0, 8'd0});
        for (int j = 0; j < N; j++) ids[j] = 5'(j);
        run_batch(1'b1, "t2");

        fill(0, {8'd0, 8'd0, 8'd77});
        fill(1, {8'd0, 8'd0, 8'd77});
        fill(2, {8'd5, 8'd0, 8'd0});
        fill(3, {8'd0, 8'd6, 8'd0});
        ids[0] = 5'd2;
        ids[1] = 5'd1;
        ids[2] = 5'd3;
        ids[3] = 5'd4;
        run_batch(1'b1, "t3");

        fill(0, {8'd7, 8'd0, 8'd0});
        fill(1, {8'd0, 8'd0, 8'd0});
        px[1][P-1] = {8'd255, 8'd0, 8'd0};
        fill(2, {8'd12, 8'd0, 8'd0});
        fill(3, {8'd3, 8'd0, 8'd0});
        for (int j = 0; j < N; j++) ids[j] = 5'(j);
        run_batch(1'b0, "t4");

        #1;
        clear_mon();
        load_t1();
        send_imgs(3, 1'b0);
        repeat (4) @(negedge clk);
        chk("t5_in_div", busy, 1'b1);
        #1 reset = 1'b1;
        #1;
        chk("t5_busy", busy, 1'b0);
        chk("t5_oval", out_valid, 1'b0);
        chk("t5_col", color_index, 2'd0);
        chk("t5_idx", image_out_index, 5'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_batch(1'b1, "t5");
        chk_t1("t5_const");

        for (int t = 0; t < 6; t++) begin
            for (int j = 0; j < N; j++) begin
                ids[j] = 5'($urandom);
                for (int k = 0; k < P; k++) begin
                    if (t % 2 == 0) px[j][k] = 24'($urandom);
                    else px[j][k] = {6'd0, 2'($urandom), 6'd0,
                                     2'($urandom), 6'd0, 2'($urandom)};
                end
            end
            run_batch(t % 3 != 0, "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
